// File: rtl/i2s_apb_sequencer.sv
// rtl/i2s_apb_sequencer.sv - APB master that feeds the I2S TxFIFO and drains the RxFIFO
module i2s_apb_sequencer #(
  parameter logic [31:0] ADR_OFFSET = 32'h0,
  parameter logic [31:0] TX_REG     = 32'h4,
  parameter logic [31:0] RX_REG     = 32'h8,
  parameter int          CNT_W      = 16
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             en,
  input  logic             tx_valid,
  input  logic [31:0]      tx_data,
  output logic             tx_ready,
  output logic             rx_valid,
  output logic [31:0]      rx_data,
  input  logic             rx_ready,
  input  logic             tx_full,
  input  logic             rx_empty,
  input  logic             rx_al_full,
  output logic [31:0]      paddr,
  output logic             pwrite,
  output logic             penable,
  output logic [31:0]      pwdata,
  input  logic [31:0]      prdata,
  output logic [CNT_W-1:0] tx_cnt,
  output logic [CNT_W-1:0] rx_cnt,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, CAPTURE, GAP} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  state_t      state_nxt;
  logic        tx_hold_v;
  logic [31:0] tx_hold;
  logic        rx_out_v;
  logic        last_tx;
  logic        cur_tx;
  logic        tx_elig;
  logic        rx_elig;
  logic        grant_tx;
  logic        grant_rx;

  assign tx_ready = !tx_hold_v;
  assign rx_valid = rx_out_v;

  // RX wins a tie when the RxFIFO is nearly full, otherwise the side not served last.
  always_comb begin
    tx_elig  = en && tx_hold_v && !tx_full;
    rx_elig  = en && !rx_empty && !rx_out_v;
    grant_rx = rx_elig && (!tx_elig || rx_al_full || last_tx);
    grant_tx = tx_elig && !grant_rx;
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_tx || grant_rx) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  state_nxt = cur_tx ? GAP : CAPTURE;
      CAPTURE: state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    penable = (state == ACCESS);
    pwrite  = cur_tx && ((state == SETUP) || (state == ACCESS));
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      tx_hold   <= '0;
      tx_hold_v <= 1'b0;
      rx_out_v  <= 1'b0;
      rx_data   <= '0;
      last_tx   <= 1'b0;
      cur_tx    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
    end else begin
      if (tx_valid && !tx_hold_v) begin
        tx_hold   <= tx_data;
        tx_hold_v <= 1'b1;
      end
      if (rx_out_v && rx_ready) rx_out_v <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_tx || grant_rx) begin
            cur_tx  <= grant_tx;
            last_tx <= grant_tx;
            paddr   <= ADR_OFFSET + (grant_tx ? TX_REG : RX_REG);
            pwdata  <= grant_tx ? tx_hold : 32'h0;
          end
        end
        ACCESS: begin
          if (cur_tx) begin
            tx_hold_v <= 1'b0;
            tx_cnt    <= tx_cnt + CNT_ONE;
          end
        end
        CAPTURE: begin
          rx_data  <= prdata;
          rx_out_v <= 1'b1;
          rx_cnt   <= rx_cnt + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_apb_sequencer.sv
// tb/tb_i2s_apb_sequencer.sv - self-checking bench for i2s_apb_sequencer
module tb_i2s_apb_sequencer;

  localparam logic [31:0] OFF = 32'h0000_1000;
  localparam int          CW  = 4;
  localparam logic [31:0] TA  = OFF + 32'h4;
  localparam logic [31:0] RA  = OFF + 32'h8;
  localparam logic [31:0] WA  = 32'hA5A5_0001;
  localparam logic [31:0] WB  = 32'h1234_5678;
  localparam logic [31:0] WD  = 32'hDEAD_BEEF;
  localparam logic [31:0] Z   = 32'h0;
  localparam logic        T   = 1'b1;
  localparam logic        F   = 1'b0;

  logic          pclk = 1'b0;
  logic          preset, en, tx_valid, rx_ready, tx_full, rx_empty, rx_al_full;
  logic [31:0]   tx_data, prdata;
  logic          tx_ready, rx_valid, pwrite, penable, busy;
  logic [31:0]   rx_data, paddr, pwdata;
  logic [CW-1:0] tx_cnt, rx_cnt;

  always #5 pclk = ~pclk;

  i2s_apb_sequencer #(.ADR_OFFSET(OFF), .TX_REG(32'h4), .RX_REG(32'h8), .CNT_W(CW)) dut (
    .pclk(pclk), .preset(preset), .en(en),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_full(tx_full), .rx_empty(rx_empty), .rx_al_full(rx_al_full),
    .paddr(paddr), .pwrite(pwrite), .penable(penable), .pwdata(pwdata), .prdata(prdata),
    .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .busy(busy)
  );

  typedef struct {
    logic          en, tv;
    logic [31:0]   td;
    logic          tf, re, raf, rr;
    logic [31:0]   pr;
    logic          busy, pen, pw, ckb;
    logic [31:0]   paddr, pwdata;
    logic          trdy, rxv;
    logic [31:0]   rxd;
    logic [CW-1:0] txc, rxc;
  } vec_t;

  vec_t vt[13];
  int checks = 0;
  int errors = 0;

  // random-phase reference state
  logic [31:0]   txq[$];
  logic [31:0]   rxq[$];
  logic [CW-1:0] m_tx, m_rx;
  logic          m_last_tx, g_tx, eb, hold, outv, te, re, acc_tx;
  int            g_at, idle_at, n, viol;
  logic          found;
  logic          got[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge pclk);
  endtask

  task automatic do_reset();
    @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);
    preset = 1'b1;
  endtask

  task automatic check_reset(input string p);
    chk({p, ".busy"}, busy, 1'b0);
    chk({p, ".penable"}, penable, 1'b0);
    chk({p, ".pwrite"}, pwrite, 1'b0);
    chk({p, ".paddr"}, paddr, Z);
    chk({p, ".pwdata"}, pwdata, Z);
    chk({p, ".tx_ready"}, tx_ready, 1'b1);
    chk({p, ".rx_valid"}, rx_valid, 1'b0);
    chk({p, ".rx_data"}, rx_data, Z);
    chk({p, ".tx_cnt"}, tx_cnt, 0);
    chk({p, ".rx_cnt"}, rx_cnt, 0);
  endtask

  task automatic idle_inputs();
    en = 0; tx_valid = 0; tx_data = 0; rx_ready = 0; tx_full = 0;
    rx_empty = 1; rx_al_full = 0; prdata = 0;
  endtask

  initial begin
    // inputs applied on one falling edge, outputs checked on the next
    vt[0]  = '{T,T,WA,F,T,F,F,Z,  F,F,F,F,Z,Z,   F,F,Z, 4'd0,4'd0};
    vt[1]  = '{T,F,Z,F,T,F,F,Z,   T,F,T,T,TA,WA, F,F,Z, 4'd0,4'd0};
    vt[2]  = '{T,F,Z,F,T,F,F,Z,   T,T,T,T,TA,WA, F,F,Z, 4'd0,4'd0};
    vt[3]  = '{T,F,Z,F,T,F,F,Z,   T,F,F,F,Z,Z,   T,F,Z, 4'd1,4'd0};
    vt[4]  = '{T,F,Z,F,F,F,F,Z,   F,F,F,F,Z,Z,   T,F,Z, 4'd1,4'd0};
    vt[5]  = '{T,F,Z,F,F,F,F,Z,   T,F,F,T,RA,Z,  T,F,Z, 4'd1,4'd0};
    vt[6]  = '{T,F,Z,F,F,F,F,Z,   T,T,F,T,RA,Z,  T,F,Z, 4'd1,4'd0};
    vt[7]  = '{T,F,Z,F,F,F,F,WD,  T,F,F,F,Z,Z,   T,F,Z, 4'd1,4'd0};
    vt[8]  = '{T,F,Z,F,F,F,F,WB,  T,F,F,F,Z,Z,   T,T,WB,4'd1,4'd1};
    vt[9]  = '{T,F,Z,F,F,F,F,Z,   F,F,F,F,Z,Z,   T,T,WB,4'd1,4'd1};
    vt[10] = '{T,F,Z,F,F,F,F,Z,   F,F,F,F,Z,Z,   T,T,WB,4'd1,4'd1};
    vt[11] = '{T,F,Z,F,F,F,T,Z,   F,F,F,F,Z,Z,   T,F,WB,4'd1,4'd1};
    vt[12] = '{T,F,Z,F,T,F,F,Z,   F,F,F,F,Z,Z,   T,F,WB,4'd1,4'd1};

    idle_inputs();
    preset = 1'b0;
    #1;
    check_reset("reset");
    step(); step();
    preset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      en = vt[i].en; tx_valid = vt[i].tv; tx_data = vt[i].td; tx_full = vt[i].tf;
      rx_empty = vt[i].re; rx_al_full = vt[i].raf; rx_ready = vt[i].rr; prdata = vt[i].pr;
      step();
      chk($sformatf("v%0d.busy", i), busy, vt[i].busy);
      chk($sformatf("v%0d.penable", i), penable, vt[i].pen);
      chk($sformatf("v%0d.pwrite", i), pwrite, vt[i].pw);
      if (vt[i].ckb) begin
        chk($sformatf("v%0d.paddr", i), paddr, vt[i].paddr);
        chk($sformatf("v%0d.pwdata", i), pwdata, vt[i].pwdata);
      end
      chk($sformatf("v%0d.tx_ready", i), tx_ready, vt[i].trdy);
      chk($sformatf("v%0d.rx_valid", i), rx_valid, vt[i].rxv);
      chk($sformatf("v%0d.rx_data", i), rx_data, vt[i].rxd);
      chk($sformatf("v%0d.tx_cnt", i), tx_cnt, vt[i].txc);
      chk($sformatf("v%0d.rx_cnt", i), rx_cnt, vt[i].rxc);
    end

    // round-robin: both sides always eligible, TX goes first
    idle_inputs();
    do_reset();
    tx_valid = 1; tx_data = $urandom;
    step();
    en = 1; rx_empty = 0; rx_ready = 1;
    n = 0;
    for (int c = 0; c < 150 && n < 6; c++) begin
      step();
      tx_data = $urandom;
      if (penable) begin
        got[n] = pwrite;
        n++;
      end
    end
    chk("rr.count", n, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("rr.grant%0d", i), got[i], (i % 2 == 0));

    // rx_al_full overrides the round-robin turn
    idle_inputs();
    do_reset();
    tx_valid = 1; tx_data = 32'hCAFE_0002;
    step();
    tx_valid = 0; rx_empty = 0; rx_al_full = 1; rx_ready = 1; en = 1;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (penable) found = 1;
    end
    chk("prio.access_seen", found, 1'b1);
    chk("prio.rx_first", pwrite, 1'b0);
    tx_full = 1; rx_empty = 1; rx_al_full = 0;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      step();
      if (!busy) found = 1;
    end
    chk("prio.idle_timeout", found, 1'b1);

    // blocked source: held word stays put while tx_full
    viol = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (penable || busy || tx_ready) viol++;
    end
    chk("bp.blocked_cycles", viol, 0);
    tx_full = 0;
    found = 0;
    for (int c = 0; c < 2 && !found; c++) begin
      step();
      if (busy && pwrite) found = 1;
    end
    chk("bp.write_after_release", found, 1'b1);
    chk("bp.pwdata", pwdata, 32'hCAFE_0002);
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      step();
      if (!busy) found = 1;
    end
    chk("bp.idle_timeout", found, 1'b1);

    // en dropped in ACCESS: transfer completes, then no more grants
    tx_valid = 1; tx_data = 32'h0BAD_F00D;
    step();
    tx_valid = 0;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      step();
      if (penable) found = 1;
    end
    chk("en.access_seen", found, 1'b1);
    en = 0;
    step();
    chk("en.gap_busy", busy, 1'b1);
    chk("en.gap_penable", penable, 1'b0);
    chk("en.tx_cnt", tx_cnt, 4'd2);
    chk("en.rx_cnt", rx_cnt, 4'd1);
    step();
    chk("en.idle", busy, 1'b0);
    tx_valid = 1; tx_data = 32'h5555_0003;
    step();
    tx_valid = 0;
    viol = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (busy) viol++;
    end
    chk("en.stays_idle", viol, 0);
    chk("en.word_held", tx_ready, 1'b0);

    // async reset in SETUP
    en = 1;
    step();
    chk("rst.setup_reached", {busy, pwrite, penable}, 3'b110);
    preset = 0;
    #1;
    check_reset("rst_setup");
    step();
    preset = 1;
    en = 0;

    // counter wrap with 4-bit counters
    tx_valid = 1; en = 1; rx_empty = 1; tx_full = 0;
    n = 0;
    for (int c = 0; c < 300 && n < 17; c++) begin
      step();
      tx_data = $urandom;
      if (penable && pwrite) begin
        n++;
        if (n == 17) begin
          chk("wrap.zero_before", tx_cnt, 4'd0);
          tx_valid = 0; en = 0;
        end
      end
    end
    chk("wrap.writes", n, 17);
    step();
    chk("wrap.tx_cnt", tx_cnt, 4'd1);

    // randomized traffic against a transaction-level model
    idle_inputs();
    do_reset();
    txq.delete(); rxq.delete();
    m_tx = 0; m_rx = 0; m_last_tx = 0; g_tx = 0; g_at = -100; idle_at = 0;
    for (int k = 0; k < 1000; k++) begin
      eb = (k < idle_at);
      chk("rnd.busy", busy, eb);
      chk("rnd.penable", penable, eb && (k == g_at + 2));
      if (eb && (k == g_at + 1 || k == g_at + 2)) begin
        chk("rnd.pwrite", pwrite, g_tx);
        chk("rnd.paddr", paddr, g_tx ? TA : RA);
        chk("rnd.pwdata", pwdata, (g_tx && txq.size() != 0) ? txq[0] : Z);
      end else begin
        chk("rnd.pwrite_off", pwrite, 1'b0);
      end
      chk("rnd.tx_ready", tx_ready, txq.size() == 0);
      chk("rnd.rx_valid", rx_valid, rxq.size() != 0);
      if (rxq.size() != 0) chk("rnd.rx_data", rx_data, rxq[0]);
      chk("rnd.tx_cnt", tx_cnt, m_tx);
      chk("rnd.rx_cnt", rx_cnt, m_rx);

      en = ($urandom_range(0, 9) != 0);
      tx_valid = $urandom_range(0, 1);
      tx_data = $urandom;
      tx_full = ($urandom_range(0, 3) == 0);
      rx_empty = ($urandom_range(0, 4) < 2);
      rx_al_full = ($urandom_range(0, 2) == 0);
      rx_ready = ($urandom_range(0, 4) < 3);
      prdata = $urandom;

      hold = (txq.size() != 0);
      outv = (rxq.size() != 0);
      acc_tx = tx_valid && !hold;
      if (outv && rx_ready) void'(rxq.pop_front());
      if (!g_tx && k == g_at + 3) begin
        rxq.push_back(prdata);
        m_rx = m_rx + 1'b1;
      end
      if (g_tx && k == g_at + 2) begin
        void'(txq.pop_front());
        m_tx = m_tx + 1'b1;
      end
      if (acc_tx) txq.push_back(tx_data);
      if (k >= idle_at) begin
        te = en && hold && !tx_full;
        re = en && !rx_empty && !outv;
        if (re && (!te || rx_al_full || m_last_tx)) begin
          g_at = k; g_tx = 0; idle_at = k + 5; m_last_tx = 0;
        end else if (te) begin
          g_at = k; g_tx = 1; idle_at = k + 4; m_last_tx = 1;
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
